// File: rtl/pwm_level_ctrl.sv
// Duty-level controller for the 5-step PWM stage: debounced up/down buttons,
// direct level loads, and a one-step-at-a-time ramp from the applied level toward the target.
module pwm_level_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int RAMP_CYCLES = 8
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       load,
  input  logic [2:0] load_level,
  output logic [2:0] level,
  output logic [2:0] target,
  output logic       at_target,
  output logic       E,
  output logic       X,
  output logic       Y
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int RW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_CYCLES - 1);
  localparam logic [2:0]    LVL_MAX   = 3'd4;

  // Bit 0 is the up button, bit 1 is the down button.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [1:0]    press;
  logic [DW-1:0] deb_cnt [2];

  logic [RW-1:0] ramp_cnt;
  logic [2:0]    level_step;
  logic [2:0]    load_clamped;
  logic [2:0]    exy_step;

  assign raw = {down, up};

  always_ff @(posedge Clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != stable[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            stable[i]  <= sync2[i];
            deb_cnt[i] <= '0;
            // Registered so the target moves on the edge after the pulse cycle.
            press[i]   <= sync2[i];
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign load_clamped = (load_level > LVL_MAX) ? LVL_MAX : load_level;

  always_ff @(posedge Clk) begin
    if (reset) begin
      target <= '0;
    end else if (load) begin
      target <= load_clamped;
    end else if (press[0] && press[1]) begin
      target <= target;
    end else if (press[0]) begin
      if (target < LVL_MAX) target <= target + 3'd1;
    end else if (press[1]) begin
      if (target != 3'd0) target <= target - 3'd1;
    end
  end

  always_comb begin
    level_step = level;
    if (level < target)      level_step = level + 3'd1;
    else if (level > target) level_step = level - 3'd1;
  end

  always_comb begin
    case (level_step)
      3'd0:    exy_step = 3'b000;
      3'd1:    exy_step = 3'b100;
      3'd2:    exy_step = 3'b101;
      3'd3:    exy_step = 3'b110;
      default: exy_step = 3'b111;
    endcase
  end

  // The ramp counter keeps running across target changes; only reaching the target parks it.
  always_ff @(posedge Clk) begin
    if (reset) begin
      ramp_cnt  <= '0;
      level     <= '0;
      {E, X, Y} <= 3'b000;
    end else if (level == target) begin
      ramp_cnt <= '0;
    end else if (ramp_cnt == RAMP_LAST) begin
      ramp_cnt  <= '0;
      level     <= level_step;
      {E, X, Y} <= exy_step;
    end else begin
      ramp_cnt <= ramp_cnt + RW'(1);
    end
  end

  assign at_target = (level == target);

endmodule
